// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer port arbiter.
package fb_pkg;

   localparam int FB_DATA_WIDTH  = 8;
   localparam int FB_ADDR_WIDTH  = 20;
   localparam int FB_DEPTH       = 76800;   // 320 x 240 pixels
   localparam int FB_WR_MAX_WAIT = 4;

   // Which requester owned the RAM port in the previous cycle (debug only).
   typedef enum logic [1:0] {
      GNT_NONE      = 2'd0,
      GNT_RD        = 2'd1,
      GNT_WR        = 2'd2,
      GNT_WR_FORCED = 2'd3
   } fb_gnt_t;

   // Tag carried alongside a read while the RAM produces its data.
   typedef struct packed {
      logic valid;
      logic err;
   } fb_rd_tag_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the frame-buffer port arbiter.
// The arbiter takes the slave modport; the requesters/RAM side take master.
interface fb_port_arbiter_if
   import fb_pkg::*;
#(
   parameter int DATA_WIDTH = FB_DATA_WIDTH,
   parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) ();

   // display read requester
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_gnt;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_err;

   // pixel write requester
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_gnt;

   // frame-buffer RAM port
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic                  ram_write;
   logic                  ram_enable;
   logic [DATA_WIDTH-1:0] ram_out_data;

   // debug
   fb_gnt_t               last_gnt;

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_out_data,
      output rd_gnt, rd_data, rd_valid, rd_err, wr_gnt,
             ram_addr, ram_data_in, ram_write, ram_enable, last_gnt
   );

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_out_data,
      input  rd_gnt, rd_data, rd_valid, rd_err, wr_gnt,
             ram_addr, ram_data_in, ram_write, ram_enable, last_gnt
   );

endinterface

// File: rtl/fb_wait_counter.sv
// Saturating count of consecutive cycles a write has been denied.
// at_max tells the arbiter the writer must be served this cycle.
module fb_wait_counter #(
   parameter int WR_MAX_WAIT = 4
) (
   input  logic CLOCK_50,
   input  logic RESET,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int                 CNT_WIDTH = $clog2(WR_MAX_WAIT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(WR_MAX_WAIT);

   logic [CNT_WIDTH-1:0] count;

   assign at_max = (count == CNT_MAX);

   // Count denied write cycles; clear wins over increment, hold at the limit.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (RESET)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && !at_max)
         count <= count + CNT_WIDTH'(1);
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port arbiter in front of the frame-buffer RAM. Reads have priority,
// a bounded-wait counter forces a write through after WR_MAX_WAIT denials,
// and read data returns with a valid/err strobe two cycles after accept.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int DATA_WIDTH  = FB_DATA_WIDTH,
   parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
   parameter int DEPTH       = FB_DEPTH,
   parameter int WR_MAX_WAIT = FB_WR_MAX_WAIT
) (
   input logic              CLOCK_50,
   input logic              RESET,
   fb_port_arbiter_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);

   logic                  rd_gnt;
   logic                  wr_gnt;
   logic                  rd_in_range;
   logic                  wr_in_range;
   logic                  wait_at_max;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic                  cmd_enable;
   logic                  cmd_write;
   fb_rd_tag_t            rd_stage1;
   fb_rd_tag_t            rd_stage2;
   fb_gnt_t               last_gnt;

   assign rd_in_range = (bus.rd_addr < DEPTH_LIMIT);
   assign wr_in_range = (bus.wr_addr < DEPTH_LIMIT);

   // Grant decision: write only when reads are idle or the writer has waited long enough.
   // NOTE: every output of an always_comb block gets a default first so no latch is inferred.
   always_comb begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
      if (!RESET) begin
         wr_gnt = bus.wr_req && (!bus.rd_req || wait_at_max);
         rd_gnt = bus.rd_req && !wr_gnt;
      end
   end

   fb_wait_counter #(
      .WR_MAX_WAIT (WR_MAX_WAIT)
   ) u_wait_counter (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .inc      (bus.wr_req && !wr_gnt),
      .clr      (wr_gnt || !bus.wr_req),
      .at_max   (wait_at_max)
   );

   // RAM command register: one access per cycle; out-of-range grants issue nothing.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         cmd_enable <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         cmd_data   <= '0;
      end else begin
         cmd_enable <= 1'b0;
         cmd_write  <= 1'b0;
         if (rd_gnt && rd_in_range) begin
            cmd_enable <= 1'b1;
            cmd_addr   <= bus.rd_addr;
         end else if (wr_gnt && wr_in_range) begin
            cmd_enable <= 1'b1;
            cmd_write  <= 1'b1;
            cmd_addr   <= bus.wr_addr;
            cmd_data   <= bus.wr_data;
         end
      end
   end

   // Read return pipeline: stage 1 tracks the command, stage 2 lines up with RAM data.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         rd_stage1 <= '0;
         rd_stage2 <= '0;
      end else begin
         rd_stage1 <= '{valid: rd_gnt, err: rd_gnt && !rd_in_range};
         rd_stage2 <= rd_stage1;
      end
   end

   // Debug record of who owned the port this cycle.
   always_ff @(posedge CLOCK_50) begin
      if (RESET)
         last_gnt <= GNT_NONE;
      else if (rd_gnt)
         last_gnt <= GNT_RD;
      else if (wr_gnt)
         last_gnt <= bus.rd_req ? GNT_WR_FORCED : GNT_WR;
      else
         last_gnt <= GNT_NONE;
   end

   assign bus.rd_gnt      = rd_gnt;
   assign bus.wr_gnt      = wr_gnt;
   assign bus.ram_addr    = cmd_addr;
   assign bus.ram_data_in = cmd_data;
   assign bus.ram_write   = cmd_write;
   assign bus.ram_enable  = cmd_enable;
   assign bus.rd_valid    = rd_stage2.valid;
   assign bus.rd_err      = rd_stage2.err;
   assign bus.last_gnt    = last_gnt;
   // RAM output is only trusted on a good read return; write echoes and idle zeros are masked.
   assign bus.rd_data     = (rd_stage2.valid && !rd_stage2.err) ? bus.ram_out_data : '0;

endmodule
